axi_sram_slave: RTL and testbench

AXI3 slave responder backed by a byte-writable on-chip word array. It terminates the AXI master port that the CPU core drives, so the core can run with no external memory controller. Its main users are the core's simulation bench and FPGA bring-up builds. Read and write channels run independently, each handling one outstanding burst at a time, with 32-bit data and INCR/FIXED bursts.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_sram_slave_mem.sv | 41 ++++
 rtl/axi_sram_slave.sv | 266 ++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 encodings, FSM state types and the beat address helper
// used by the SRAM-backed slave responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  // WRAP is handled as INCR and the reserved code as FIXED.
  function automatic logic [31:0] beat_next(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    logic inc;
    inc = (burst == BURST_INCR) || (burst == BURST_WRAP);
    return inc ? addr + (32'd1 << size) : addr;
  endfunction

endpackage

// File: rtl/axi_sram_slave_mem.sv
// Word array with one synchronous read port and one byte-enabled
// write port; a same-edge read returns the pre-write contents.
module axi_sram_slave_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [31:0]       rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [3:0]        wr_strb_i,
  input  logic [31:0]       wr_data_i
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) begin
          mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q <= 32'h0;
    end else if (rd_en_i) begin
      rd_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating the core's master port onto on-chip SRAM.
// Independent read and write FSMs, one outstanding burst each.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam logic [3:0] LAT = 4'(READ_LAT);

  r_state_t    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [3:0]  r_lat_q, r_lat_d;
  logic [3:0]  rid_q, rid_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic        arready_q, arready_d;
  logic        rd_en;
  logic [31:0] r_next;
  logic [ADDR_W-1:0] rd_idx;

  w_state_t    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [7:0]  w_cnt_q, w_cnt_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [3:0]  bid_q, bid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        bvalid_q, bvalid_d;
  logic        wready_q, wready_d;
  logic        awready_q, awready_d;
  logic        wr_en;
  logic        w_end;

  logic unused_wid;
  assign unused_wid = ^wid;

  assign r_next = beat_next(r_addr_q, r_size_q, r_burst_q);

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_lat_d   = r_lat_q;
    rid_d     = rid_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    arready_d = arready_q;
    rd_en     = 1'b0;
    rd_idx    = r_addr_q[ADDR_W+1:2];
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_addr_d  = araddr;
          r_len_d   = arlen;
          r_size_d  = arsize;
          r_burst_d = arburst;
          rid_d     = arid;
          r_cnt_d   = 8'd0;
          r_lat_d   = 4'd0;
          arready_d = 1'b0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_lat_q == LAT) begin
          rd_en     = 1'b1;
          rvalid_d  = 1'b1;
          rlast_d   = (r_len_q == 8'd0);
          r_state_d = R_BURST;
        end else begin
          r_lat_d = r_lat_q + 4'd1;
        end
      end
      R_BURST: begin
        if (rready && rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end else if (rready) begin
          r_addr_d = r_next;
          r_cnt_d  = r_cnt_q + 8'd1;
          rd_en    = 1'b1;
          rd_idx   = r_next[ADDR_W+1:2];
          rlast_d  = (r_cnt_q + 8'd1 == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign w_end = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    bvalid_d  = bvalid_q;
    wready_d  = wready_q;
    awready_d = awready_q;
    wr_en     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_size_d  = awsize;
          w_burst_d = awburst;
          bid_d     = awid;
          w_cnt_d   = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          wr_en = 1'b1;
          // A burst ends on wlast or on the final counted beat;
          // a disagreement between the two is a protocol error.
          if (wlast || w_end) begin
            bresp_d   = (wlast && w_end) ? RESP_OKAY : RESP_SLVERR;
            bvalid_d  = 1'b1;
            wready_d  = 1'b0;
            w_state_d = W_RESP;
          end else begin
            w_addr_d = beat_next(w_addr_q, w_size_q, w_burst_q);
            w_cnt_d  = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 32'h0;
      r_len_q   <= 8'd0;
      r_cnt_q   <= 8'd0;
      r_size_q  <= 3'd0;
      r_burst_q <= 2'd0;
      r_lat_q   <= 4'd0;
      rid_q     <= 4'd0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b1;
      w_state_q <= W_IDLE;
      w_addr_q  <= 32'h0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_size_q  <= 3'd0;
      w_burst_q <= 2'd0;
      bid_q     <= 4'd0;
      bresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      awready_q <= 1'b1;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_lat_q   <= r_lat_d;
      rid_q     <= rid_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      wready_q  <= wready_d;
      awready_q <= awready_d;
    end
  end

  axi_sram_slave_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i    (clk),
    .rst_i    (rst),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_idx),
    .rd_data_o(rdata),
    .wr_en_i  (wr_en),
    .wr_addr_i(w_addr_q[ADDR_W+1:2]),
    .wr_strb_i(wstrb),
    .wr_data_i(wdata)
  );

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rresp   = RESP_OKAY;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave against a word-array model
// with per-byte validity masks.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] ref_msk [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_d [256];
  logic        rd_l [256];
  logic [1:0]  rd_r [256];
  logic [3:0]  rd_i [256];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a,
                                        input logic [1:0] burst,
                                        input int i);
    if (burst == 2'b01 || burst == 2'b10) return a + 32'(i * 4);
    return a;
  endfunction

  function automatic logic [31:0] exp_d(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_m(input int idx);
    return ref_msk.exists(idx) ? ref_msk[idx] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] burst,
                             input int nb);
    int idx;
    logic [31:0] d, m;
    for (int i = 0; i < nb; i++) begin
      idx = widx(baddr(a, burst, i));
      d = exp_d(idx);
      m = exp_m(idx);
      for (int b = 0; b < 4; b++) begin
        if (ws[i][b]) begin
          d[8*b +: 8] = wd[i][8*b +: 8];
          m[8*b +: 8] = 8'hFF;
        end
      end
      ref_mem[idx] = d;
      ref_msk[idx] = m;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] id,
                          input int nb, input bit with_last,
                          output logic [1:0] resp, output logic [3:0] rb,
                          output bit bimm, output bit to);
    int guard;
    logic rdy;
    to = 0; bimm = 0; resp = 2'bxx; rb = 4'bxxxx;
    awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = burst;
    awvalid = 1'b1;
    guard = 0;
    do begin
      rdy = awready; @(posedge clk); #1; guard++;
    end while (!rdy && guard < 100);
    awvalid = 1'b0;
    if (!rdy) begin to = 1; return; end
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0; @(posedge clk); #1;
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = with_last && (i == nb - 1); wid = 4'($urandom);
      guard = 0;
      do begin
        rdy = wready; @(posedge clk); #1; guard++;
      end while (!rdy && guard < 100);
      if (!rdy) begin wvalid = 1'b0; wlast = 1'b0; to = 1; return; end
    end
    wvalid = 1'b0; wlast = 1'b0;
    bimm = bvalid;
    guard = 0;
    while (bvalid !== 1'b1 && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (bvalid !== 1'b1) begin to = 1; return; end
    resp = bresp; rb = bid;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] burst, input logic [3:0] id,
                         input int mode, output int nbeats, output int lat,
                         output int se, output bit to);
    int guard, hs;
    bit done, stalled, r, tog;
    logic rdy;
    logic [31:0] pd;
    logic pl;
    logic [3:0] pid;
    nbeats = 0; lat = -1; se = 0; to = 0;
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = burst;
    arvalid = 1'b1;
    guard = 0;
    do begin
      rdy = arready; @(posedge clk); #1; guard++;
    end while (!rdy && guard < 100);
    arvalid = 1'b0;
    if (!rdy) begin to = 1; return; end
    hs = cyc;
    done = 0; stalled = 0; tog = 1; guard = 0;
    pd = '0; pl = 1'b0; pid = '0;
    while (!done && guard < 2000) begin
      r = 0;
      if (rvalid === 1'b1) begin
        if (lat < 0) lat = cyc - hs;
        if (stalled && (rdata !== pd || rlast !== pl || rid !== pid)) se++;
        case (mode)
          0: r = 1;
          1: begin r = tog; tog = !tog; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        if (r) begin
          rd_d[nbeats] = rdata; rd_l[nbeats] = rlast;
          rd_r[nbeats] = rresp; rd_i[nbeats] = rid;
          nbeats++;
          stalled = 0;
          if (rlast === 1'b1 || nbeats > int'(len)) done = 1;
        end else begin
          stalled = 1; pd = rdata; pl = rlast; pid = rid;
        end
      end else begin
        if (stalled) se++;
        stalled = 0;
      end
      rready = r;
      @(posedge clk); #1; guard++;
    end
    rready = 1'b0;
    to = !done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b110000)
      $display("FAIL reset_ctrl got %b want 110000",
               {arready, awready, wready, rvalid, rlast, bvalid});
    else passed++;
    total++;
    if ({rdata, rid, rresp, bid, bresp} !== 44'h0)
      $display("FAIL reset_data got %h want 0", {rdata, rid, rresp, bid, bresp});
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000)
      $display("FAIL post_reset got %b want 11000",
               {arready, awready, wready, rvalid, bvalid});
    else passed++;
  endtask

  task automatic test_single_read();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h100, 8'd0, BURST_INCR, 4'h3, 1, 1, resp, rb, bimm, to);
    model_write(32'h100, BURST_INCR, 1);
    total++;
    if (to || resp !== RESP_OKAY || rb !== 4'h3)
      $display("FAIL single_write got to=%0d resp=%0h bid=%0h want 0/0/3", to, resp, rb);
    else passed++;
    total++;
    if (bimm !== 1'b1) $display("FAIL bvalid_timing got %b want 1", bimm);
    else passed++;
    do_read(32'h100, 8'd0, BURST_INCR, 4'h9, 0, nb, lat, se, to);
    total++;
    if (to || nb != 1) $display("FAIL single_beats got %0d want 1", nb);
    else passed++;
    total++;
    if (lat != 1 + READ_LAT) $display("FAIL read_latency got %0d want %0d", lat, 1 + READ_LAT);
    else passed++;
    total++;
    if (rd_d[0] !== 32'hDEADBEEF) $display("FAIL single_rdata got %h want deadbeef", rd_d[0]);
    else passed++;
    total++;
    if ({rd_l[0], rd_r[0], rd_i[0]} !== 7'b1_00_1001)
      $display("FAIL single_rlast_resp_id got %b want 1001001", {rd_l[0], rd_r[0], rd_i[0]});
    else passed++;
    total++;
    if (arready !== 1'b1) $display("FAIL arready_after got %b want 1", arready);
    else passed++;
  endtask

  task automatic test_incr_burst();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h40, 8'd3, BURST_INCR, 4'h5, 4, 1, resp, rb, bimm, to);
    model_write(32'h40, BURST_INCR, 4);
    total++;
    if (to || resp !== RESP_OKAY) $display("FAIL incr_bresp got %0h want 0", resp);
    else passed++;
    do_read(32'h40, 8'd3, BURST_INCR, 4'hC, 1, nb, lat, se, to);
    total++;
    if (to || nb != 4 || se != 0)
      $display("FAIL incr_beats_stall got nb=%0d se=%0d want 4/0", nb, se);
    else passed++;
    for (int i = 0; i < nb && i < 4; i++) begin
      total++;
      if (rd_d[i] !== exp_d(widx(32'h40 + 32'(4 * i))) || rd_l[i] !== (i == 3) || rd_i[i] !== 4'hC)
        $display("FAIL incr_beat%0d got %h/%b want %h/%b", i, rd_d[i], rd_l[i],
                 exp_d(widx(32'h40 + 32'(4 * i))), i == 3);
      else passed++;
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(32'h200, 8'd0, BURST_INCR, 4'h1, 1, 1, resp, rb, bimm, to);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(32'h200, 8'd0, BURST_INCR, 4'hA, 1, 1, resp, rb, bimm, to);
    total++;
    if (to || resp !== RESP_OKAY || rb !== 4'hA)
      $display("FAIL strobe_b got resp=%0h bid=%0h want 0/a", resp, rb);
    else passed++;
    do_read(32'h200, 8'd0, BURST_INCR, 4'h2, 0, nb, lat, se, to);
    total++;
    if (to || rd_d[0] !== 32'h00220044) $display("FAIL strobe_data got %h want 00220044", rd_d[0]);
    else passed++;
    ref_mem[widx(32'h200)] = 32'h00220044;
    ref_msk[widx(32'h200)] = 32'hFFFFFFFF;
  endtask

  task automatic test_wlast_errors();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h300, 8'd3, BURST_INCR, 4'h4, 4, 1, resp, rb, bimm, to);
    model_write(32'h300, BURST_INCR, 4);
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h300, 8'd3, BURST_INCR, 4'h6, 2, 1, resp, rb, bimm, to);
    model_write(32'h300, BURST_INCR, 2);
    total++;
    if (to || resp !== RESP_SLVERR || rb !== 4'h6)
      $display("FAIL early_wlast got to=%0d resp=%0h bid=%0h want 0/2/6", to, resp, rb);
    else passed++;
    total++;
    if (awready !== 1'b1) $display("FAIL awready_after_b got %b want 1", awready);
    else passed++;
    do_read(32'h300, 8'd3, BURST_INCR, 4'h0, 2, nb, lat, se, to);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (to || rd_d[i] !== exp_d(widx(32'h300 + 32'(4 * i))))
        $display("FAIL early_word%0d got %h want %h", i, rd_d[i],
                 exp_d(widx(32'h300 + 32'(4 * i))));
      else passed++;
    end
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h400, 8'd1, BURST_INCR, 4'h7, 2, 0, resp, rb, bimm, to);
    model_write(32'h400, BURST_INCR, 2);
    total++;
    if (to || resp !== RESP_SLVERR) $display("FAIL missing_wlast got %0h want 2", resp);
    else passed++;
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    for (int i = 0; i < 3; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h80, 8'd2, BURST_FIXED, 4'h8, 3, 1, resp, rb, bimm, to);
    model_write(32'h80, BURST_FIXED, 3);
    total++;
    if (to || resp !== RESP_OKAY) $display("FAIL fixed_bresp got %0h want 0", resp);
    else passed++;
    do_read(32'h80, 8'd2, BURST_FIXED, 4'h3, 0, nb, lat, se, to);
    total++;
    if (to || nb != 3) $display("FAIL fixed_beats got %0d want 3", nb);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_d[i] !== 32'h3 || rd_l[i] !== (i == 2))
        $display("FAIL fixed_beat%0d got %h/%b want 3/%b", i, rd_d[i], rd_l[i], i == 2);
      else passed++;
    end
  endtask

  task automatic test_wrap_around();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se;
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    wd[0] = w0; wd[1] = w1; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(32'h3FFC, 8'd1, BURST_INCR, 4'h2, 2, 1, resp, rb, bimm, to);
    model_write(32'h3FFC, BURST_INCR, 2);
    do_read(32'h0, 8'd0, BURST_INCR, 4'h1, 0, nb, lat, se, to);
    total++;
    if (to || rd_d[0] !== w1) $display("FAIL wrap_word0 got %h want %h", rd_d[0], w1);
    else passed++;
    do_read(32'h8000_7FFC, 8'd1, BURST_INCR, 4'h1, 2, nb, lat, se, to);
    total++;
    if (to || rd_d[0] !== w0 || rd_d[1] !== w1)
      $display("FAIL wrap_alias got %h %h want %h %h", rd_d[0], rd_d[1], w0, w1);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int guard, nb, lat, se;
    bit to;
    arid = 4'h2; araddr = 32'h40; arlen = 8'd3; arsize = 3'd2;
    arburst = BURST_INCR; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    guard = 0;
    while (rvalid !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    total++;
    if (rvalid !== 1'b1) $display("FAIL midrst_start got rvalid=%b want 1", rvalid);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rvalid, rlast, arready, awready} !== 4'b0011)
      $display("FAIL midrst_async got %b want 0011", {rvalid, rlast, arready, awready});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(32'h40, 8'd3, BURST_INCR, 4'hE, 0, nb, lat, se, to);
    total++;
    if (to || nb != 4 || rd_d[3] !== exp_d(widx(32'h4C)) || rd_i[3] !== 4'hE)
      $display("FAIL midrst_next got nb=%0d d=%h want 4/%h", nb, rd_d[3], exp_d(widx(32'h4C)));
    else passed++;
  endtask

  task automatic test_overlap();
    logic [1:0] resp; logic [3:0] rb; bit bimm, wto, rto;
    int nb, lat, se;
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h2800, 8'd7, BURST_INCR, 4'h1, 8, 1, resp, rb, bimm, wto);
    model_write(32'h2800, BURST_INCR, 8);
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write(32'h2000, 8'd7, BURST_INCR, 4'hB, 8, 1, resp, rb, bimm, wto);
      do_read(32'h2800, 8'd7, BURST_INCR, 4'hD, 2, nb, lat, se, rto);
    join
    model_write(32'h2000, BURST_INCR, 8);
    total++;
    if (wto || rto || resp !== RESP_OKAY || rb !== 4'hB || nb != 8 || se != 0)
      $display("FAIL overlap_ctrl got wto=%0d rto=%0d resp=%0h nb=%0d se=%0d want 0/0/0/8/0",
               wto, rto, resp, nb, se);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (rd_d[i] !== exp_d(widx(32'h2800 + 32'(4 * i))))
        $display("FAIL overlap_beat%0d got %h want %h", i, rd_d[i],
                 exp_d(widx(32'h2800 + 32'(4 * i))));
      else passed++;
    end
    do_read(32'h2000, 8'd7, BURST_INCR, 4'h0, 0, nb, lat, se, rto);
    total++;
    if (rto || rd_d[7] !== exp_d(widx(32'h201C)))
      $display("FAIL overlap_wdata got %h want %h", rd_d[7], exp_d(widx(32'h201C)));
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [3:0] rb; bit bimm, to;
    int nb, lat, se, idx;
    logic [31:0] a;
    logic [7:0] len;
    logic [1:0] wb, rbst;
    for (int it = 0; it < 12; it++) begin
      a = $urandom & 32'hF000_3FFC;
      len = 8'($urandom_range(0, 7));
      wb = 2'($urandom_range(0, 3));
      rbst = 2'($urandom_range(0, 3));
      for (int i = 0; i <= int'(len); i++) begin
        wd[i] = $urandom; ws[i] = 4'($urandom);
      end
      do_write(a, len, wb, 4'(it), int'(len) + 1, 1, resp, rb, bimm, to);
      model_write(a, wb, int'(len) + 1);
      total++;
      if (to || resp !== RESP_OKAY || rb !== 4'(it))
        $display("FAIL rand%0d_b got resp=%0h bid=%0h want 0/%0h", it, resp, rb, 4'(it));
      else passed++;
      do_read(a, len, rbst, 4'(it + 3), 2, nb, lat, se, to);
      total++;
      if (to || nb != int'(len) + 1 || se != 0)
        $display("FAIL rand%0d_r got nb=%0d se=%0d want %0d/0", it, nb, se, int'(len) + 1);
      else passed++;
      for (int i = 0; i < nb && i <= int'(len); i++) begin
        idx = widx(baddr(a, rbst, i));
        total++;
        if (((rd_d[i] ^ exp_d(idx)) & exp_m(idx)) !== 32'h0 ||
            rd_l[i] !== (i == int'(len)) || rd_r[i] !== 2'b00)
          $display("FAIL rand%0d_beat%0d got %h/%b want %h mask %h/%b", it, i,
                   rd_d[i], rd_l[i], exp_d(idx), exp_m(idx), i == int'(len));
        else passed++;
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_read();
    test_incr_burst();
    test_strobes();
    test_wlast_errors();
    test_fixed();
    test_wrap_around();
    test_reset_mid_burst();
    test_overlap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
